// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: I-side refill requester, D-side
// refill/writeback requester, the shared memory channel and the grant status.
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (both caches plus the memory controller).
`ifndef CLP
`define CLP 128
`endif

interface mem_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = `CLP
);
  logic              i_strobe_i;
  logic [XLEN-1:0]   i_addr_i;
  logic              i_done_o;
  logic [CLSIZE-1:0] i_data_o;

  logic              d_strobe_i;
  logic [XLEN-1:0]   d_addr_i;
  logic              d_rw_i;
  logic [CLSIZE-1:0] d_data_i;
  logic              d_done_o;
  logic [CLSIZE-1:0] d_data_o;

  logic              M_MEM_strobe_o;
  logic [XLEN-1:0]   M_MEM_addr_o;
  logic              M_MEM_rw_o;
  logic [CLSIZE-1:0] M_MEM_data_o;
  logic              M_MEM_done_i;
  logic [CLSIZE-1:0] M_MEM_data_i;

  logic [1:0]        grant_o;

  modport slave (
    input  i_strobe_i, i_addr_i,
    input  d_strobe_i, d_addr_i, d_rw_i, d_data_i,
    input  M_MEM_done_i, M_MEM_data_i,
    output i_done_o, i_data_o,
    output d_done_o, d_data_o,
    output M_MEM_strobe_o, M_MEM_addr_o, M_MEM_rw_o, M_MEM_data_o,
    output grant_o
  );

  modport master (
    output i_strobe_i, i_addr_i,
    output d_strobe_i, d_addr_i, d_rw_i, d_data_i,
    output M_MEM_done_i, M_MEM_data_i,
    input  i_done_o, i_data_o,
    input  d_done_o, d_data_o,
    input  M_MEM_strobe_o, M_MEM_addr_o, M_MEM_rw_o, M_MEM_data_o,
    input  grant_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cache-line memory port between the I-cache
// refill path and the D-cache refill/writeback path. One transaction at a
// time, IDLE -> BUSY -> RESP -> GAP, with every output driven from a flop.
// Optional build macro MEM_ARB_RR_EN selects round-robin tie breaking;
// without it the D side wins every tie.
module mem_port_arbiter #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = `CLP
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  state_t state_q, state_d;

  logic              strobe_q, strobe_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [CLSIZE-1:0] wdata_q, wdata_d;
  logic [1:0]        grant_q, grant_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [CLSIZE-1:0] i_rdata_q, i_rdata_d;
  logic [CLSIZE-1:0] d_rdata_q, d_rdata_d;

  logic any_req;
  logic pick_d;

  assign any_req = bus.i_strobe_i | bus.d_strobe_i;

`ifdef MEM_ARB_RR_EN
  // 1 means the D side owned the most recent grant.
  logic last_grant_d_q, last_grant_d_d;

  // On a tie hand the port to whichever side did not get it last time.
  always_comb begin
    if (bus.i_strobe_i && bus.d_strobe_i) begin
      pick_d = ~last_grant_d_q;
    end else begin
      pick_d = bus.d_strobe_i;
    end
  end

  // Remember who won; reset leaves it on D so the first tie goes to I.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_d_q <= 1'b1;
    end else begin
      last_grant_d_q <= last_grant_d_d;
    end
  end
`else
  // Fixed priority: the D side wins whenever it is requesting.
  always_comb begin
    pick_d = bus.d_strobe_i;
  end
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests only count in IDLE, memory completion only in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = BUSY;
      BUSY: if (bus.M_MEM_done_i) state_d = RESP;
      RESP: state_d = GAP;
      GAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs for the current state.
  always_comb begin
    strobe_d  = strobe_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    grant_d   = grant_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d_d = last_grant_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          strobe_d = 1'b1;
          if (pick_d) begin
            grant_d = GRANT_D;
            addr_d  = bus.d_addr_i;
            rw_d    = bus.d_rw_i;
            wdata_d = bus.d_data_i;
          end else begin
            grant_d = GRANT_I;
            addr_d  = bus.i_addr_i;
            rw_d    = 1'b0;
            wdata_d = '0;
          end
`ifdef MEM_ARB_RR_EN
          last_grant_d_d = pick_d;
`endif
        end
      end
      BUSY: begin
        if (bus.M_MEM_done_i) begin
          strobe_d = 1'b0;
          if (grant_q == GRANT_D) begin
            d_done_d  = 1'b1;
            d_rdata_d = bus.M_MEM_data_i;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = bus.M_MEM_data_i;
          end
        end
      end
      RESP: begin
        grant_d = GRANT_NONE;
      end
      GAP: begin
        grant_d = GRANT_NONE;
      end
      default: begin
        grant_d = GRANT_NONE;
      end
    endcase
  end

  // Output registers; reset clears everything, abandoning any in-flight access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      strobe_q  <= 1'b0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      grant_q   <= GRANT_NONE;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      strobe_q  <= strobe_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      grant_q   <= grant_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.M_MEM_strobe_o = strobe_q;
  assign bus.M_MEM_addr_o   = addr_q;
  assign bus.M_MEM_rw_o     = rw_q;
  assign bus.M_MEM_data_o   = wdata_q;
  assign bus.grant_o        = grant_q;
  assign bus.i_done_o       = i_done_q;
  assign bus.d_done_o       = d_done_q;
  assign bus.i_data_o       = i_rdata_q;
  assign bus.d_data_o       = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Expected tie order
// follows MEM_ARB_RR_EN when the bench is built with that macro.
module tb_mem_port_arbiter;

  localparam int XLEN   = 32;
  localparam int CLSIZE = 128;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus ();

  mem_port_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(
    input logic              i_stb,
    input logic [XLEN-1:0]   i_addr,
    input logic              d_stb,
    input logic [XLEN-1:0]   d_addr,
    input logic              d_rw,
    input logic [CLSIZE-1:0] d_data,
    input logic              m_done,
    input logic [CLSIZE-1:0] m_data
  );
    bus.i_strobe_i   = i_stb;
    bus.i_addr_i     = i_addr;
    bus.d_strobe_i   = d_stb;
    bus.d_addr_i     = d_addr;
    bus.d_rw_i       = d_rw;
    bus.d_data_i     = d_data;
    bus.M_MEM_done_i = m_done;
    bus.M_MEM_data_i = m_data;
  endtask

  task automatic checkOutput(input string tag, input logic [CLSIZE-1:0] act,
                             input logic [CLSIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    tick();
    rst_i = 1'b0;
  endtask

  // Wait (bounded) for the memory strobe to come up.
  task automatic waitStrobe();
    for (int n = 0; n < 20; n++) begin
      if (bus.M_MEM_strobe_o) break;
      tick();
    end
    checkOutput("strobe_wait", bus.M_MEM_strobe_o, 1);
  endtask

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [CLSIZE-1:0] pat_a5, pat_12, pat_55, pat_f0;
    logic [1:0]        first_g, second_g;
    logic [XLEN-1:0]   first_addr, second_addr;
    logic [1:0]        exp_order [3];

    pat_a5 = {4{32'hA5A5_A5A5}};
    pat_12 = {4{32'h1234_5678}};
    pat_55 = {4{32'h55AA_55AA}};
    pat_f0 = {4{32'hF0F0_F0F0}};

`ifdef MEM_ARB_RR_EN
    first_g = 2'b01; second_g = 2'b10;
    first_addr = 32'h0000_0100; second_addr = 32'h0000_0200;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
`else
    first_g = 2'b10; second_g = 2'b01;
    first_addr = 32'h0000_0200; second_addr = 32'h0000_0100;
    exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b10;
`endif

    // Reset values
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    tick();
    tick();
    checkOutput("rst strobe", bus.M_MEM_strobe_o, 0);
    checkOutput("rst grant", bus.grant_o, 2'b00);
    checkOutput("rst i_done", bus.i_done_o, 0);
    checkOutput("rst d_done", bus.d_done_o, 0);
    checkOutput("rst addr", bus.M_MEM_addr_o, 0);
    rst_i = 1'b0;

    // I-only read, request in cycle 0
    $display("[TB] I-only read");
    applyStimulus(1, 32'h8000_0040, 0, '0, 0, '0, 0, '0);
    tick();
    checkOutput("i_rd strobe c1", bus.M_MEM_strobe_o, 1);
    checkOutput("i_rd grant c1", bus.grant_o, 2'b01);
    checkOutput("i_rd addr", bus.M_MEM_addr_o, 32'h8000_0040);
    checkOutput("i_rd rw", bus.M_MEM_rw_o, 0);
    repeat (4) tick();
    checkOutput("i_rd strobe c5", bus.M_MEM_strobe_o, 1);
    checkOutput("i_rd done early", bus.i_done_o, 0);
    applyStimulus(1, 32'h8000_0040, 0, '0, 0, '0, 1, pat_a5);
    tick();
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    checkOutput("i_rd done c6", bus.i_done_o, 1);
    checkOutput("i_rd data", bus.i_data_o, pat_a5);
    checkOutput("i_rd grant c6", bus.grant_o, 2'b01);
    checkOutput("i_rd strobe c6", bus.M_MEM_strobe_o, 0);
    checkOutput("i_rd d_done", bus.d_done_o, 0);
    tick();
    checkOutput("i_rd done c7", bus.i_done_o, 0);
    checkOutput("i_rd grant c7", bus.grant_o, 2'b00);
    tick();

    // D write
    $display("[TB] D write");
    applyStimulus(0, '0, 1, 32'h8000_1000, 1, pat_12, 0, '0);
    tick();
    checkOutput("d_wr grant", bus.grant_o, 2'b10);
    checkOutput("d_wr rw", bus.M_MEM_rw_o, 1);
    checkOutput("d_wr addr", bus.M_MEM_addr_o, 32'h8000_1000);
    checkOutput("d_wr wdata", bus.M_MEM_data_o, pat_12);
    applyStimulus(0, '0, 1, 32'h8000_1000, 1, pat_12, 1, pat_55);
    tick();
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    checkOutput("d_wr d_done", bus.d_done_o, 1);
    checkOutput("d_wr i_done", bus.i_done_o, 0);
    checkOutput("d_wr d_data", bus.d_data_o, pat_55);
    checkOutput("d_wr i_data hold", bus.i_data_o, pat_a5);
    tick();
    checkOutput("d_wr d_done off", bus.d_done_o, 0);
    tick();

    // Single tie, then loser served after the guard cycles
    $display("[TB] tie");
    doReset();
    applyStimulus(1, 32'h0000_0100, 1, 32'h0000_0200, 0, '0, 0, '0);
    tick();
    checkOutput("tie first grant", bus.grant_o, first_g);
    checkOutput("tie first addr", bus.M_MEM_addr_o, first_addr);
    applyStimulus(1, 32'h0000_0100, 1, 32'h0000_0200, 0, '0, 1, pat_f0);
    tick();
    checkOutput("tie first i_done", bus.i_done_o, first_g == 2'b01);
    checkOutput("tie first d_done", bus.d_done_o, first_g == 2'b10);
    applyStimulus(second_g == 2'b01, 32'h0000_0100, second_g == 2'b10,
                  32'h0000_0200, 0, '0, 0, '0);
    tick();
    checkOutput("tie gap grant", bus.grant_o, 2'b00);
    tick();
    checkOutput("tie idle grant", bus.grant_o, 2'b00);
    checkOutput("tie idle strobe", bus.M_MEM_strobe_o, 0);
    tick();
    checkOutput("tie second grant", bus.grant_o, second_g);
    checkOutput("tie second addr", bus.M_MEM_addr_o, second_addr);
    bus.M_MEM_done_i = 1'b1;
    tick();
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    checkOutput("tie second i_done", bus.i_done_o, second_g == 2'b01);
    checkOutput("tie second d_done", bus.d_done_o, second_g == 2'b10);
    repeat (3) tick();

    // Three back-to-back ties with both strobes held
    $display("[TB] three ties");
    doReset();
    applyStimulus(1, 32'h0000_0100, 1, 32'h0000_0200, 0, '0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      waitStrobe();
      checkOutput($sformatf("tie3 grant %0d", k), bus.grant_o, exp_order[k]);
      bus.M_MEM_done_i = 1'b1;
      bus.M_MEM_data_i = {4{32'hC0DE_0000 + 32'(k)}};
      tick();
      bus.M_MEM_done_i = 1'b0;
      checkOutput($sformatf("tie3 d_done %0d", k), bus.d_done_o, exp_order[k] == 2'b10);
      checkOutput($sformatf("tie3 i_done %0d", k), bus.i_done_o, exp_order[k] == 2'b01);
    end
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    repeat (3) tick();

    // Reset while BUSY, then a late memory completion
    $display("[TB] reset mid-busy");
    applyStimulus(0, '0, 1, 32'h0000_0300, 0, '0, 0, '0);
    tick();
    checkOutput("rstb strobe", bus.M_MEM_strobe_o, 1);
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rstb strobe off", bus.M_MEM_strobe_o, 0);
    checkOutput("rstb grant", bus.grant_o, 2'b00);
    checkOutput("rstb addr", bus.M_MEM_addr_o, 0);
    checkOutput("rstb d_data", bus.d_data_o, 0);
    applyStimulus(0, '0, 0, '0, 0, '0, 1, pat_55);
    tick();
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    checkOutput("rstb late d_done", bus.d_done_o, 0);
    checkOutput("rstb late i_done", bus.i_done_o, 0);
    checkOutput("rstb late grant", bus.grant_o, 2'b00);

    // Spurious completion in IDLE
    $display("[TB] spurious done");
    applyStimulus(0, '0, 0, '0, 0, '0, 1, pat_f0);
    tick();
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    checkOutput("spur i_done", bus.i_done_o, 0);
    checkOutput("spur d_done", bus.d_done_o, 0);
    checkOutput("spur i_data", bus.i_data_o, 0);
    checkOutput("spur strobe", bus.M_MEM_strobe_o, 0);
    tick();
    checkOutput("spur grant", bus.grant_o, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external cache-line memory port between the I-cache refill path and the D-cache refill/writeback path.
- Sits between the two caches (or the atomic unit on the D side) and the single AXI master memory channel.
- Serializes transactions with a four-state FSM, fixed or round-robin priority, and registered request/response paths.

Parameters:
- XLEN, 32, address width in bits.
- CLSIZE, `CLP, cache-line width in bits (data width of every port).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- i_strobe_i  input  1  I-side request; held high until i_done_o
- i_addr_i  input  XLEN  I-side line address
- i_done_o  output  1  I-side completion pulse
- i_data_o  output  CLSIZE  I-side read line
- d_strobe_i  input  1  D-side request; held high until d_done_o
- d_addr_i  input  XLEN  D-side line address
- d_rw_i  input  1  D-side direction: 1 = write, 0 = read
- d_data_i  input  CLSIZE  D-side write line
- d_done_o  output  1  D-side completion pulse
- d_data_o  output  CLSIZE  D-side read line
- M_MEM_strobe_o  output  1  memory request, level
- M_MEM_addr_o  output  XLEN  memory address
- M_MEM_rw_o  output  1  memory direction
- M_MEM_data_o  output  CLSIZE  memory write data
- M_MEM_done_i  input  1  memory completion
- M_MEM_data_i  input  CLSIZE  memory read data
- grant_o  output  2  current owner: 00 none, 01 I, 10 D

Behaviour:
- Single clock domain (clk_i); synchronous active-high reset rst_i. All outputs are registered.
- Reset values: every output 0, FSM in IDLE, last_grant = D.
- FSM states:
  - IDLE: if any strobe is high, select a winner and latch its addr, rw (forced 0 for I), and write data into the M_MEM_* registers; set grant_o; go to BUSY. Otherwise stay in IDLE.
  - BUSY: M_MEM_strobe_o = 1. The other requester is ignored. On M_MEM_done_i = 1, latch M_MEM_data_i into the winner's data_o, pulse the winner's done_o, drop M_MEM_strobe_o, go to RESP.
  - RESP: done_o is high for exactly this one cycle; clear it at the next edge; go to GAP.
  - GAP: one-cycle guard so the requester can drop its strobe; arbitration disabled; clear grant_o; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle t drives M_MEM_strobe_o high at t+1.
  - M_MEM_done_i at cycle u drives done_o and data_o valid at u+1.
  - Next arbitration happens no earlier than u+3.
- Data handling:
  - data_o holds its value until the next completion for the same side.
  - On a write, data_o is loaded with M_MEM_data_i (don't care to the requester).
  - The non-granted side's done_o is never asserted.
- Boundary conditions:
  - M_MEM_done_i outside BUSY is ignored.
  - Requester strobes outside IDLE are ignored; a strobe that is held persists and is served later.
  - A strobe dropped before grant is treated as withdrawn; no transaction is issued.
  - Reset mid-transaction returns to IDLE with outputs cleared. The in-flight memory transaction is abandoned; the memory controller shares rst_i.
- Priority:
  - Simultaneous requests in IDLE use the priority rule below.
  - A single requester is always granted.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the side opposite last_grant.
  - last_grant updates on every grant.
  - The first tie after reset goes to I (last_grant resets to D).
- MEM_ARB_RR_EN undefined: fixed priority, D over I on every tie. The last_grant register is omitted.

Test Plan:
- I-only read: i_strobe_i = 1, i_addr_i = 0x8000_0040; done at cycle 5 with data 0xA5A5...
  -> M_MEM_strobe_o = 1 in cycles 1–5, M_MEM_addr_o = 0x8000_0040, M_MEM_rw_o = 0.
  -> i_done_o = 1 in cycle 6 only; i_data_o = 0xA5A5...; grant_o = 01 in cycles 1–6.
- D write: d_rw_i = 1, d_addr_i = 0x8000_1000, d_data_i = 0x1234...
  -> M_MEM_rw_o = 1, M_MEM_data_o = 0x1234..., d_done_o pulses once, i_done_o stays 0.
- Tie, fixed priority: both strobes high in the same cycle
  -> D served first; I granted no earlier than 3 cycles after D's M_MEM_done_i.
- Tie, MEM_ARB_RR_EN: three back-to-back ties
  -> grant order I, D, I.
- Reset mid-BUSY: assert rst_i one cycle while M_MEM_strobe_o = 1
  -> next cycle all outputs 0, grant_o = 00; a late M_MEM_done_i is ignored (no done_o).
- Spurious done: M_MEM_done_i = 1 while in IDLE
  -> no done_o, state unchanged.
